par_check_pipe: RTL and testbench

Parametrised, registered parity/zero/gate checker for the HCM sequential test-circuit set. It is the next generation of the fixed 4-input, 3-flag netlist: WIDTH-bit input bus, two register stages, and the same three-flag S output. It adds a run-length detector FSM and an optional saturating event counter. It is a leaf block and also serves as a golden model for SAT/equivalence runs.

---
 rtl/par_check_pkg.sv | 16 +
 rtl/par_check_run_det.sv | 46 ++++
 rtl/par_check_pipe.sv | 71 +++++++
 tb/tb_par_check_pipe.sv | 126 ++++++++++++
 4 files changed

// File: rtl/par_check_pkg.sv
// rtl/par_check_pkg.sv - shared run-state enum, flag indices and reset value for par_check_pipe
package par_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HIT
  } run_state_e;

  localparam int S_PAT  = 0;
  localparam int S_MIS  = 1;
  localparam int S_STAT = 2;

  localparam logic [2:0] S_RST = 3'b100;

endpackage

// File: rtl/par_check_run_det.sv
// rtl/par_check_run_det.sv - run-length detector: hit after RUN_LEN consecutive pattern cycles
module par_check_run_det
  import par_check_pkg::*;
#(
  parameter int RUN_LEN = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic pat,
  output logic hit
);

  localparam int RW = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

  run_state_e    state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic          hit_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    if (!pat) begin
      state_d = ST_IDLE;
      r_d     = '0;
    end else if (state_q != ST_HIT) begin
      r_d     = r_q + 1'b1;
      state_d = (r_d == RUN_MAX) ? ST_HIT : ST_RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      hit_q   <= (state_d == ST_HIT);
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/par_check_pipe.sv
// rtl/par_check_pipe.sv - two-stage parity/zero/gate checker with run detector; PAR_CHECK_EVT_CNT_EN adds EVT_CNT
module par_check_pipe
  import par_check_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             EN,
  output logic [2:0]       S,
  output logic             HIT
`ifdef PAR_CHECK_EVT_CNT_EN
  ,
  output logic [CNT_W-1:0] EVT_CNT
`endif
);

  logic [WIDTH-1:0] i_q;
  logic             p_q, z_q, g_q;

  // EN is used unregistered here, so it pairs with the I captured one edge earlier
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_q <= '0;
      p_q <= 1'b0;
      z_q <= 1'b0;
      g_q <= 1'b0;
    end else begin
      i_q <= I;
      p_q <= ^i_q;
      z_q <= ~|i_q[WIDTH-1:1];
      g_q <= (^i_q) | (EN & i_q[0]) | ~(EN & i_q[WIDTH-1]);
    end
  end

  always_comb begin
    S         = '0;
    S[S_PAT]  = p_q & z_q;
    S[S_MIS]  = p_q ^ g_q;
    S[S_STAT] = z_q | ~g_q;
  end

  par_check_run_det #(
    .RUN_LEN(RUN_LEN)
  ) u_run (
    .CLK(CLK),
    .RST(RST),
    .pat(S[S_PAT]),
    .hit(HIT)
  );

`ifdef PAR_CHECK_EVT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (S[S_MIS] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign EVT_CNT = cnt_q;
`else
  wire unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_par_check_pipe.sv
// tb/tb_par_check_pipe.sv - directed self-checking bench for par_check_pipe (EVT_CNT checks with PAR_CHECK_EVT_CNT_EN)
module tb_par_check_pipe;
  import par_check_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] I;
  logic       EN;
  logic [2:0] S;
  logic       HIT;
`ifdef PAR_CHECK_EVT_CNT_EN
  logic [1:0] EVT_CNT;
`endif

  int vectors = 0;
  int miscompares = 0;

  par_check_pipe #(
    .WIDTH(4),
    .RUN_LEN(3),
    .CNT_W(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .I(I),
    .EN(EN),
    .S(S),
    .HIT(HIT)
`ifdef PAR_CHECK_EVT_CNT_EN
    ,
    .EVT_CNT(EVT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] exp);
`ifdef PAR_CHECK_EVT_CNT_EN
    chk(tag, {6'b0, EVT_CNT}, exp);
`endif
  endtask

  initial begin
    // reset with busy inputs
    RST = 1'b1; I = 4'hF; EN = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_s", {5'b0, S}, {5'b0, S_RST});
      chk("rst_hit", {7'b0, HIT}, 8'h0);
      chk_cnt("rst_cnt", 8'h0);
    end

    // pattern held: stage B first sees the cleared I_q, then 0001
    RST = 1'b0; I = 4'b0001; EN = 1'b0;
    tick(); chk("s2_e1_s", {5'b0, S}, 8'h06);
    tick(); chk("s2_e2_s", {5'b0, S}, 8'h05); chk("s2_e2_hit", {7'b0, HIT}, 8'h0);
    tick(); chk("s2_e3_hit", {7'b0, HIT}, 8'h0);
    tick(); chk("s2_e4_hit", {7'b0, HIT}, 8'h0);
    tick(); chk("s2_e5_hit", {7'b0, HIT}, 8'h1);
    tick(); chk("s2_e6_hit", {7'b0, HIT}, 8'h1); chk("s2_e6_s", {5'b0, S}, 8'h05);

    // reset mid-run, then a full restart
    RST = 1'b1; tick();
    RST = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("s5_pre_hit", {7'b0, HIT}, 8'h0);
    RST = 1'b1; tick();
    chk("s5_rst_hit", {7'b0, HIT}, 8'h0);
    chk("s5_rst_s", {5'b0, S}, 8'h04);
    chk("s5_rst_r", {6'b0, dut.u_run.r_q}, 8'h0);
    RST = 1'b0;
    tick(); chk("s5_r1_s", {5'b0, S}, 8'h06);
    tick(); tick(); tick();
    chk("s5_r4_hit", {7'b0, HIT}, 8'h0);
    tick(); chk("s5_r5_hit", {7'b0, HIT}, 8'h1);

    // mismatch stream; first count comes from the post-reset S=110 bubble
    RST = 1'b1; tick();
    RST = 1'b0; I = 4'b0011; EN = 1'b1;
    tick(); chk("s3_e1_s", {5'b0, S}, 8'h06); chk_cnt("s3_e1_cnt", 8'h0);
    tick(); chk("s3_e2_s", {5'b0, S}, 8'h02); chk_cnt("s3_e2_cnt", 8'h1);
    tick(); chk_cnt("s3_e3_cnt", 8'h2);
    tick(); chk_cnt("s3_e4_cnt", 8'h3);
    tick(); chk_cnt("s3_e5_cnt", 8'h3);
    tick(); chk_cnt("s3_e6_cnt", 8'h3); chk("s3_hit", {7'b0, HIT}, 8'h0);

    // short pattern burst must not reach HIT
    I = 4'b1010; EN = 1'b1;
    tick(); tick(); chk("s4_base_s", {5'b0, S}, 8'h04);
    I = 4'b0001;
    tick(); chk("s4_x0_s", {5'b0, S}, 8'h04);
    EN = 1'b0;
    tick(); chk("s4_x1_s", {5'b0, S}, 8'h05);
    I = 4'b1010;
    tick(); chk("s4_x2_s", {5'b0, S}, 8'h05); chk("s4_x2_r", {6'b0, dut.u_run.r_q}, 8'h1);
    EN = 1'b1;
    tick(); chk("s4_x3_s", {5'b0, S}, 8'h04); chk("s4_x3_r", {6'b0, dut.u_run.r_q}, 8'h2);
    chk("s4_x3_hit", {7'b0, HIT}, 8'h0);
    tick(); chk("s4_x4_r", {6'b0, dut.u_run.r_q}, 8'h0); chk("s4_x4_hit", {7'b0, HIT}, 8'h0);

    // EN pairs with the I captured one edge before
    I = 4'b1100; EN = 1'b0;
    tick();
    EN = 1'b1;
    tick(); chk("en1_s", {5'b0, S}, 8'h04);
    EN = 1'b0;
    tick(); chk("en0_s", {5'b0, S}, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
